// File: rtl/tex_pkg.sv
// rtl/tex_pkg.sv - shared constants and state type for the texture refill controller
//
// Purpose: default line/beat geometry and the refill FSM state encoding,
//          imported by tex_refill_ctrl.
// Contents:
//   TEX_LINE_BYTES  default cache line size in bytes
//   TEX_BEAT_BYTES  default memory read beat width in bytes
//   refill_state_t  IDLE / REQ / FILL / RESP

package tex_pkg;

  localparam int TEX_LINE_BYTES = 64;
  localparam int TEX_BEAT_BYTES = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    FILL = 2'd2,
    RESP = 2'd3
  } refill_state_t;

endpackage

// File: rtl/tex_refill_ctrl.sv
// rtl/tex_refill_ctrl.sv - texture cache line refill controller
//
// Purpose: accepts one line-refill request from the cache, issues a single
//          line-aligned burst read to memory, assembles the returned beats
//          into a line buffer and reports the completed line with a
//          one-cycle response pulse.
// Optional feature: define TEX_REFILL_PERF_EN to build the refill and busy
//          cycle counters; otherwise the perf ports are tied to 0.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   miss_req_*        refill request from the cache (valid/ready, byte address)
//   miss_resp_*       one-cycle completion pulse and the assembled line
//   mem_req_*         burst read request (valid/ready, base address, beats-1)
//   mem_r*            read beat stream (valid/ready, data)
//   perf_refills      completed refills (wraps)
//   perf_busy_cycles  cycles spent outside IDLE (wraps)

module tex_refill_ctrl
  import tex_pkg::*;
#(
  parameter int LINE_BYTES = TEX_LINE_BYTES,
  parameter int BEAT_BYTES = TEX_BEAT_BYTES
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    miss_req_valid,
  input  logic [31:0]             miss_req_addr,
  output logic                    miss_req_ready,
  output logic                    miss_resp_valid,
  output logic [LINE_BYTES*8-1:0] miss_resp_data,
  output logic                    mem_req_valid,
  output logic [31:0]             mem_req_addr,
  output logic [7:0]              mem_req_len,
  input  logic                    mem_req_ready,
  input  logic                    mem_rvalid,
  input  logic [BEAT_BYTES*8-1:0] mem_rdata,
  output logic                    mem_rready,
  output logic [31:0]             perf_refills,
  output logic [31:0]             perf_busy_cycles
);

  localparam int BEATS  = LINE_BYTES / BEAT_BYTES;
  localparam int BEAT_W = BEAT_BYTES * 8;
  localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;

  localparam logic [CNT_W-1:0] LAST_BEAT   = CNT_W'(BEATS - 1);
  localparam logic [31:0]      OFFSET_MASK = 32'(LINE_BYTES - 1);

  refill_state_t           state_q;
  refill_state_t           state_d;
  logic [CNT_W-1:0]        beat_q;
  logic [31:0]             addr_q;
  logic [LINE_BYTES*8-1:0] line_q;

  logic accept;
  logic beat_fire;
  logic last_beat;

  assign accept    = miss_req_valid && (state_q == IDLE);
  // Beats are only consumed in FILL; anything arriving elsewhere is dropped.
  assign beat_fire = mem_rvalid && (state_q == FILL);
  assign last_beat = beat_fire && (beat_q == LAST_BEAT);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept)        state_d = REQ;
      REQ:     if (mem_req_ready) state_d = FILL;
      FILL:    if (last_beat)     state_d = RESP;
      RESP:                       state_d = IDLE;
      default:                    state_d = IDLE;
    endcase
  end

  // Output logic: all handshake outputs decode directly from the state so
  // an asynchronous reset drops them in the same instant.
  always_comb begin
    miss_req_ready  = 1'b0;
    mem_req_valid   = 1'b0;
    mem_rready      = 1'b0;
    miss_resp_valid = 1'b0;
    case (state_q)
      IDLE:    miss_req_ready  = 1'b1;
      REQ:     mem_req_valid   = 1'b1;
      FILL:    mem_rready      = 1'b1;
      RESP:    miss_resp_valid = 1'b1;
      default: miss_req_ready  = 1'b0;
    endcase
  end

  assign mem_req_addr   = addr_q;
  assign mem_req_len    = 8'(BEATS - 1);
  assign miss_resp_data = line_q;

  // Beat index and captured line-aligned address
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_q <= '0;
      addr_q <= '0;
    end else begin
      if (accept) begin
        addr_q <= miss_req_addr & ~OFFSET_MASK;
        beat_q <= '0;
      end else if (beat_fire) begin
        beat_q <= last_beat ? '0 : beat_q + 1'b1;
      end
    end
  end

  // Line buffer carries no reset; it is only written by accepted beats, so
  // the last completed line stays visible until the next fill overwrites it.
  always_ff @(posedge clk) begin
    if (beat_fire) begin
      line_q[int'(beat_q)*BEAT_W +: BEAT_W] <= mem_rdata;
    end
  end

`ifdef TEX_REFILL_PERF_EN
  logic [31:0] refills_q;
  logic [31:0] busy_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      refills_q <= '0;
      busy_q    <= '0;
    end else begin
      if (state_q == RESP) begin
        refills_q <= refills_q + 32'd1;
      end
      if (state_q != IDLE) begin
        busy_q <= busy_q + 32'd1;
      end
    end
  end

  assign perf_refills     = refills_q;
  assign perf_busy_cycles = busy_q;
`else
  assign perf_refills     = 32'd0;
  assign perf_busy_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_tex_refill_ctrl.sv
// tb/tb_tex_refill_ctrl.sv - directed self-checking bench for tex_refill_ctrl

module tb_tex_refill_ctrl;

  localparam int LB    = 64;
  localparam int BB    = 4;
  localparam int BEATS = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              miss_req_valid = 1'b0;
  logic [31:0]       miss_req_addr = '0;
  logic              miss_req_ready;
  logic              miss_resp_valid;
  logic [LB*8-1:0]   miss_resp_data;
  logic              mem_req_valid;
  logic [31:0]       mem_req_addr;
  logic [7:0]        mem_req_len;
  logic              mem_req_ready = 1'b0;
  logic              mem_rvalid = 1'b0;
  logic [BB*8-1:0]   mem_rdata = '0;
  logic              mem_rready;
  logic [31:0]       perf_refills;
  logic [31:0]       perf_busy_cycles;

  int checks   = 0;
  int failures = 0;

  tex_refill_ctrl #(
    .LINE_BYTES(LB),
    .BEAT_BYTES(BB)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .miss_req_valid   (miss_req_valid),
    .miss_req_addr    (miss_req_addr),
    .miss_req_ready   (miss_req_ready),
    .miss_resp_valid  (miss_resp_valid),
    .miss_resp_data   (miss_resp_data),
    .mem_req_valid    (mem_req_valid),
    .mem_req_addr     (mem_req_addr),
    .mem_req_len      (mem_req_len),
    .mem_req_ready    (mem_req_ready),
    .mem_rvalid       (mem_rvalid),
    .mem_rdata        (mem_rdata),
    .mem_rready       (mem_rready),
    .perf_refills     (perf_refills),
    .perf_busy_cycles (perf_busy_cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Inputs are driven and outputs sampled 1ns after the rising edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One complete refill. stall: cycles with mem_req_ready low; gaps: idle
  // cycles (k%3) before beat k; hold: keep miss_req_valid high throughout;
  // stray: mem_rvalid pulses with junk data while in REQ.
  task automatic do_refill(input string tag, input logic [31:0] addr,
                           input logic [31:0] base, input int stall,
                           input bit gaps, input bit hold, input bit stray);
    int          req_seen = 0;
    int          early    = 0;
    int          rdy_bad  = 0;
    int          acc_bad  = 0;
    int          hold_bad = 0;
    logic [31:0] exp_addr;
    exp_addr = addr & ~32'h3F;

    chk({tag, ".idle_ready"}, miss_req_ready, 1);
    miss_req_valid = 1'b1;
    miss_req_addr  = addr;
    tick;
    if (!hold) miss_req_valid = 1'b0;
    chk({tag, ".req_valid"}, mem_req_valid, 1);
    chk({tag, ".req_addr"}, mem_req_addr, exp_addr);
    chk({tag, ".req_len"}, mem_req_len, 15);
    chk({tag, ".req_busy"}, miss_req_ready, 0);

    for (int s = 0; s < stall; s++) begin
      mem_req_ready = 1'b0;
      if (stray) begin
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hDEAD_0000 + s;
      end
      tick;
      mem_rvalid = 1'b0;
      if (mem_req_valid !== 1'b1 || mem_req_addr !== exp_addr) hold_bad++;
    end
    chk({tag, ".req_held"}, hold_bad, 0);
    mem_req_ready = 1'b1;
    tick;
    mem_req_ready = 1'b0;

    for (int k = 0; k < BEATS; k++) begin
      if (gaps) begin
        for (int g = 0; g < k % 3; g++) begin
          mem_rvalid = 1'b0;
          if (mem_req_valid) req_seen++;
          if (miss_resp_valid) early++;
          if (mem_rready !== 1'b1) rdy_bad++;
          if (miss_req_ready !== 1'b0) acc_bad++;
          tick;
        end
      end
      if (mem_req_valid) req_seen++;
      if (miss_resp_valid) early++;
      if (mem_rready !== 1'b1) rdy_bad++;
      if (miss_req_ready !== 1'b0) acc_bad++;
      mem_rvalid = 1'b1;
      mem_rdata  = base + k;
      tick;
    end
    mem_rvalid = 1'b0;

    chk({tag, ".extra_req"}, req_seen, 0);
    chk({tag, ".early_resp"}, early, 0);
    chk({tag, ".fill_rready"}, rdy_bad, 0);
    chk({tag, ".fill_noaccept"}, acc_bad, 0);
    chk({tag, ".resp_pulse"}, miss_resp_valid, 1);
    chk({tag, ".resp_busy"}, miss_req_ready, 0);
    chk({tag, ".resp_rready"}, mem_rready, 0);
    for (int k = 0; k < BEATS; k++) begin
      chk($sformatf("%s.word%0d", tag, k), miss_resp_data[k*32 +: 32], base + k);
    end

    tick;
    chk({tag, ".pulse_end"}, miss_resp_valid, 0);
    chk({tag, ".back_ready"}, miss_req_ready, 1);
    if (hold) miss_req_valid = 1'b0;
    tick;
    chk({tag, ".pulse_once"}, miss_resp_valid, 0);
    chk({tag, ".no_reaccept"}, mem_req_valid, 0);
    chk({tag, ".data_stable"}, miss_resp_data[31:0], base);
  endtask

  initial begin
    // Reset state
    repeat (2) tick;
    chk("rst.mem_req_valid", mem_req_valid, 0);
    chk("rst.mem_rready", mem_rready, 0);
    chk("rst.resp_valid", miss_resp_valid, 0);
    chk("rst.perf_refills", perf_refills, 0);
    chk("rst.perf_busy", perf_busy_cycles, 0);
    rst = 1'b0;
    tick;
    chk("rst.ready_after", miss_req_ready, 1);

    // Basic refill, always-ready memory, minimum latency
    do_refill("basic", 32'h0000_1234, 32'h100, 0, 1'b0, 1'b0, 1'b0);

    // Backpressure on the request plus gaps between beats
    do_refill("bp", 32'h0000_ABCD, 32'h2000, 5, 1'b1, 1'b0, 1'b0);

    // Request held high through the whole refill
    do_refill("hold", 32'h0001_0040, 32'h3000, 0, 1'b0, 1'b1, 1'b0);

    // Stray beats in IDLE, then in REQ
    for (int i = 0; i < 3; i++) begin
      mem_rvalid = 1'b1;
      mem_rdata  = 32'hBEEF_0000 + i;
      tick;
    end
    mem_rvalid = 1'b0;
    chk("stray.idle_resp", miss_resp_valid, 0);
    chk("stray.idle_ready", miss_req_ready, 1);
    chk("stray.idle_rready", mem_rready, 0);
    do_refill("stray", 32'h0000_2000, 32'h5000, 3, 1'b0, 1'b0, 1'b1);

    // Reset in the middle of a fill after beat 7
    miss_req_valid = 1'b1;
    miss_req_addr  = 32'h0000_3000;
    tick;
    miss_req_valid = 1'b0;
    mem_req_ready  = 1'b1;
    tick;
    mem_req_ready  = 1'b0;
    for (int k = 0; k < 8; k++) begin
      mem_rvalid = 1'b1;
      mem_rdata  = 32'hBAD0 + k;
      tick;
    end
    rst = 1'b1;
    #1;
    chk("midrst.rready", mem_rready, 0);
    chk("midrst.req_valid", mem_req_valid, 0);
    chk("midrst.resp_valid", miss_resp_valid, 0);
    chk("midrst.perf_refills", perf_refills, 0);
    tick;
    rst = 1'b0;
    tick;
    mem_rvalid = 1'b0;
    chk("midrst.late_resp", miss_resp_valid, 0);
    chk("midrst.ready", miss_req_ready, 1);
    do_refill("after_rst", 32'h0000_4000, 32'h400, 0, 1'b0, 1'b0, 1'b0);

    // Perf counters over three back-to-back basic refills
    rst = 1'b1;
    tick;
    rst = 1'b0;
    tick;
    for (int r = 0; r < 3; r++) begin
      miss_req_valid = 1'b1;
      miss_req_addr  = 32'h0000_1234;
      tick;
      miss_req_valid = 1'b0;
      mem_req_ready  = 1'b1;
      tick;
      mem_req_ready  = 1'b0;
      for (int k = 0; k < BEATS; k++) begin
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h100 + k;
        tick;
      end
      mem_rvalid = 1'b0;
      chk($sformatf("perf.pulse%0d", r), miss_resp_valid, 1);
      tick;
    end
`ifdef TEX_REFILL_PERF_EN
    chk("perf.refills", perf_refills, 3);
    chk("perf.busy", perf_busy_cycles, 54);
`else
    chk("perf.refills_off", perf_refills, 0);
    chk("perf.busy_off", perf_busy_cycles, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
